// File: rtl/cc_pkg.sv
// Shared types, flag bit positions and the condition decode used by the
// condition-code unit and by sequencer models.
package cc_pkg;

  typedef logic [3:0] flags_t;

  localparam int unsigned F_Z = 3;
  localparam int unsigned F_N = 2;
  localparam int unsigned F_C = 1;
  localparam int unsigned F_V = 0;

  typedef enum logic [3:0] {
    CC_NEVER = 4'h0,
    CC_JMP   = 4'h1,
    CC_CALL  = 4'h2,
    CC_RET   = 4'h3,
    CC_EQ    = 4'h4,
    CC_NE    = 4'h5,
    CC_CS    = 4'h6,
    CC_CC    = 4'h7,
    CC_MI    = 4'h8,
    CC_PL    = 4'h9,
    CC_VS    = 4'hA,
    CC_VC    = 4'hB,
    CC_GE    = 4'hC,
    CC_LT    = 4'hD,
    CC_UGT   = 4'hE,
    CC_ULE   = 4'hF
  } cond_e;

  function automatic flags_t pack_flags(input logic z, input logic n,
                                        input logic c, input logic v);
    flags_t f;
    f      = '0;
    f[F_Z] = z;
    f[F_N] = n;
    f[F_C] = c;
    f[F_V] = v;
    return f;
  endfunction

  // Unknown select codes fall to the default arm, so tcnd never goes X.
  function automatic logic cond_eval(input logic [3:0] sel, input flags_t f);
    logic z, n, c, v, r;
    z = f[F_Z];
    n = f[F_N];
    c = f[F_C];
    v = f[F_V];
    r = 1'b0;
    case (sel)
      CC_NEVER:                r = 1'b0;
      CC_JMP, CC_CALL, CC_RET: r = 1'b1;
      CC_EQ:                   r = z;
      CC_NE:                   r = !z;
      CC_CS:                   r = c;
      CC_CC:                   r = !c;
      CC_MI:                   r = n;
      CC_PL:                   r = !n;
      CC_VS:                   r = v;
      CC_VC:                   r = !v;
      CC_GE:                   r = (n == v);
      CC_LT:                   r = (n != v);
      CC_UGT:                  r = c && !z;
      CC_ULE:                  r = !c || z;
      default:                 r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cc_flag_stack.sv
// LIFO of flag words for call/interrupt save and restore. Saturating count,
// sticky error on overflow, underflow or simultaneous push and pop.
module cc_flag_stack
  import cc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  flags_t                       din,
  output flags_t                       top,
  output logic                         pop_ok,
  output logic [$clog2(DEPTH+1)-1:0]   cnt,
  output logic                         err
);

  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SLOTS = 1 << AW;

  flags_t          mem [SLOTS];
  logic            full;
  logic            empty;
  logic            push_ok;
  logic            bad;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push && !pop && !full;
  assign pop_ok  = pop && !push && !empty;
  assign bad     = (push && pop) || (push && full) || (pop && empty);

  assign wr_idx  = AW'(cnt);
  assign rd_idx  = AW'(cnt - CW'(1));
  assign top     = mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (push_ok) begin
        cnt <= cnt + CW'(1);
      end else if (pop_ok) begin
        cnt <= cnt - CW'(1);
      end
      if (bad) begin
        err <= 1'b1;
      end
    end
  end

  // Contents are don't-care after reset, so storage carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/cond_code_unit.sv
// Condition-code unit: registers ALU flags, evaluates the condition select
// into tcnd for the sequencer, and saves/restores flags on a small stack.
module cond_code_unit
  import cc_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned DEPTH  = 4,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [3:0]                  cont,
  input  logic [DW-1:0]               aluo,
  input  logic                        aluc,
  input  logic                        aluv,
  input  logic                        flag_we,
  input  logic                        push,
  input  logic                        pop,
  output logic                        tcnd,
  output logic [3:0]                  flags,
  output logic [$clog2(DEPTH+1)-1:0]  stk_cnt,
  output logic                        stk_err
);

  flags_t new_flags;
  flags_t eff_flags;
  flags_t stk_top;
  logic   stk_pop;

  assign new_flags = pack_flags(aluo == '0, aluo[DW-1], aluc, aluv);
  assign eff_flags = (BYPASS && flag_we) ? new_flags : flags;
  assign tcnd      = cond_eval(cont, eff_flags);

  cc_flag_stack #(
    .DEPTH (DEPTH)
  ) u_stack (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (pop),
    .din    (eff_flags),
    .top    (stk_top),
    .pop_ok (stk_pop),
    .cnt    (stk_cnt),
    .err    (stk_err)
  );

  // A valid restore wins over a same-cycle ALU flag load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= '0;
    end else if (stk_pop) begin
      flags <= stk_top;
    end else if (flag_we) begin
      flags <= new_flags;
    end
  end

endmodule

// File: tb/tb_cond_code_unit.sv
// Bench for cond_code_unit: two instances (DW=8/BYPASS=1 and DW=16/BYPASS=0),
// directed stimulus queues expectations, a negedge monitor pops and compares.
module tb_cond_code_unit;

  localparam logic [3:0] M_T   = 4'b1000;
  localparam logic [3:0] M_F   = 4'b0100;
  localparam logic [3:0] M_C   = 4'b0010;
  localparam logic [3:0] M_E   = 4'b0001;
  localparam logic [3:0] M_REG = 4'b0111;
  localparam logic [3:0] M_ALL = 4'b1111;

  typedef struct {
    int         d;
    string      name;
    logic [3:0] m;
    logic       t;
    logic [3:0] f;
    logic [2:0] c;
    logic       e;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  cont0, cont1;
  logic [7:0]  aluo0;
  logic [15:0] aluo1;
  logic        aluc0, aluc1, aluv0, aluv1, we0, we1, push0, push1, pop0, pop1;
  logic        tcnd0, tcnd1, err0, err1;
  logic [3:0]  flags0, flags1;
  logic [2:0]  cnt0, cnt1;

  cond_code_unit #(.DW(8), .DEPTH(4), .BYPASS(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .cont(cont0), .aluo(aluo0), .aluc(aluc0),
    .aluv(aluv0), .flag_we(we0), .push(push0), .pop(pop0), .tcnd(tcnd0),
    .flags(flags0), .stk_cnt(cnt0), .stk_err(err0)
  );

  cond_code_unit #(.DW(16), .DEPTH(4), .BYPASS(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .cont(cont1), .aluo(aluo1), .aluc(aluc1),
    .aluv(aluv1), .flag_we(we1), .push(push1), .pop(pop1), .tcnd(tcnd1),
    .flags(flags1), .stk_cnt(cnt1), .stk_err(err1)
  );

  function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
    logic z, n, cy, v;
    {z, n, cy, v} = f;
    case (c)
      4'h0:             return 1'b0;
      4'h1, 4'h2, 4'h3: return 1'b1;
      4'h4:             return z;
      4'h5:             return !z;
      4'h6:             return cy;
      4'h7:             return !cy;
      4'h8:             return n;
      4'h9:             return !n;
      4'hA:             return v;
      4'hB:             return !v;
      4'hC:             return n == v;
      4'hD:             return n != v;
      4'hE:             return cy & !z;
      default:          return !cy | z;
    endcase
  endfunction

  function automatic logic [15:0] nval(input int d);
    return (d == 0) ? 16'h0080 : 16'h8000;
  endfunction

  // ALU result that produces the Z/N part of flag pattern f
  function automatic logic [15:0] aluo_for(input int d, input logic [3:0] f);
    if (f[3]) return 16'h0000;
    if (f[2]) return nval(d);
    return (d == 0) ? 16'h0011 : 16'h0100;
  endfunction

  task automatic drive(input int d, input logic [3:0] c, input logic [15:0] a,
                       input logic cy, input logic v, input logic we,
                       input logic pu, input logic po);
    if (d == 0) begin
      cont0 = c; aluo0 = a[7:0]; aluc0 = cy; aluv0 = v; we0 = we; push0 = pu; pop0 = po;
    end else begin
      cont1 = c; aluo1 = a; aluc1 = cy; aluv1 = v; we1 = we; push1 = pu; pop1 = po;
    end
  endtask

  task automatic expect_out(input int d, input string n, input logic [3:0] m,
                            input logic t, input logic [3:0] f,
                            input logic [2:0] c, input logic e);
    exp_t x;
    x.d = d; x.name = n; x.m = m; x.t = t; x.f = f; x.c = c; x.e = e;
    sbq.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input string fld, input logic [3:0] act,
                     input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h at %0t", n, fld, act, req, $time);
    end
  endtask

  // Monitor: outputs are stable at the falling edge
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      while (sbq.size() != 0) begin
        x = sbq.pop_front();
        if (x.m[3]) chk(x.name, "tcnd",    {3'b0, (x.d == 0) ? tcnd0 : tcnd1}, {3'b0, x.t});
        if (x.m[2]) chk(x.name, "flags",   (x.d == 0) ? flags0 : flags1, x.f);
        if (x.m[1]) chk(x.name, "stk_cnt", {1'b0, (x.d == 0) ? cnt0 : cnt1}, {1'b0, x.c});
        if (x.m[0]) chk(x.name, "stk_err", {3'b0, (x.d == 0) ? err0 : err1}, {3'b0, x.e});
      end
    end
  end

  task automatic seq_basic(input int d, input logic byp);
    rst_n = 1'b0;
    drive(d, 4'h1, 16'h0, 0, 0, 0, 0, 0);
    expect_out(d, "rst_state", M_ALL, 1'b1, 4'h0, 3'd0, 1'b0);
    step(); rst_n = 1'b1;
    drive(d, 4'h4, 16'h0, 0, 0, 0, 0, 0);
    expect_out(d, "t1_no_we", M_ALL, 1'b0, 4'h0, 3'd0, 1'b0);
    step(); drive(d, 4'h4, 16'h0, 0, 0, 1, 0, 0);
    expect_out(d, "t1_bypass", M_T | M_F, byp, 4'h0, 3'd0, 1'b0);
    step(); drive(d, 4'h4, 16'h0, 0, 0, 0, 0, 0);
    expect_out(d, "t1_loaded", M_T | M_F, 1'b1, 4'h8, 3'd0, 1'b0);
    // save Z, overwrite with N, restore while ALU also loads
    step(); drive(d, 4'h0, 16'h0, 0, 0, 0, 1, 0);
    expect_out(d, "t3_pre_push", M_REG, 1'b0, 4'h8, 3'd0, 1'b0);
    step(); drive(d, 4'h0, nval(d), 0, 0, 1, 0, 0);
    expect_out(d, "t3_pushed", M_REG, 1'b0, 4'h8, 3'd1, 1'b0);
    step(); drive(d, 4'h0, 16'h0001, 0, 0, 1, 0, 1);
    expect_out(d, "t3_n_loaded", M_REG, 1'b0, 4'h4, 3'd1, 1'b0);
    step(); drive(d, 4'h0, 16'h0, 0, 0, 0, 0, 0);
    expect_out(d, "t3_restored", M_REG, 1'b0, 4'h8, 3'd0, 1'b0);
    // push source: bypassed ALU flags or registered flags
    step(); drive(d, 4'h0, nval(d), 1, 0, 1, 1, 0);
    expect_out(d, "push_src_a", M_REG, 1'b0, 4'h8, 3'd0, 1'b0);
    step(); drive(d, 4'h0, 16'h0, 0, 1, 1, 0, 0);
    expect_out(d, "push_src_b", M_REG, 1'b0, 4'h6, 3'd1, 1'b0);
    step(); drive(d, 4'h0, 16'h0, 0, 0, 0, 0, 1);
    expect_out(d, "push_src_c", M_REG, 1'b0, 4'h9, 3'd1, 1'b0);
    step(); drive(d, 4'h0, 16'h0, 0, 0, 0, 0, 0);
    expect_out(d, "push_src", M_REG, 1'b0, byp ? 4'h6 : 4'h8, 3'd0, 1'b0);
  endtask

  task automatic seq_sweep(input int d);
    logic [3:0] fv;
    for (int f = 0; f < 16; f++) begin
      fv = 4'(f);
      if (!(fv[3] && fv[2])) begin
        step(); drive(d, 4'h0, aluo_for(d, fv), fv[1], fv[0], 1, 0, 0);
        for (int c = 0; c < 16; c++) begin
          step(); drive(d, 4'(c), 16'h0, 0, 0, 0, 0, 0);
          expect_out(d, $sformatf("sweep_f%h_c%h", fv, c), M_T | M_F,
                     m_cond(4'(c), fv), fv, 3'd0, 1'b0);
        end
      end
    end
    step(); drive(d, 4'h0, nval(d), 0, 0, 1, 0, 0);
    step(); drive(d, 4'hD, 16'h0, 0, 0, 0, 0, 0);
    expect_out(d, "hand_lt", M_T, 1'b1, 4'h4, 3'd0, 1'b0);
    step(); drive(d, 4'hC, 16'h0, 0, 0, 0, 0, 0);
    expect_out(d, "hand_ge", M_T, 1'b0, 4'h4, 3'd0, 1'b0);
    step(); drive(d, 4'hE, 16'h0, 0, 0, 0, 0, 0);
    expect_out(d, "hand_ugt", M_T, 1'b0, 4'h4, 3'd0, 1'b0);
    step(); drive(d, 4'hF, 16'h0, 0, 0, 0, 0, 0);
    expect_out(d, "hand_ule", M_T, 1'b1, 4'h4, 3'd0, 1'b0);
  endtask

  task automatic seq_stack(input int d, input logic byp);
    logic [15:0] pa [4];
    logic        pc [4];
    logic        pv [4];
    logic [3:0]  fs [4];
    logic [3:0]  st [4];
    pa = '{16'h0, nval(d), 16'h0001, 16'h0001};
    pc = '{1'b0, 1'b0, 1'b1, 1'b0};
    pv = '{1'b0, 1'b0, 1'b0, 1'b1};
    fs = '{4'h8, 4'h4, 4'h2, 4'h1};
    for (int i = 0; i < 4; i++) st[i] = byp ? fs[i] : ((i == 0) ? 4'h0 : fs[i-1]);

    step(); rst_n = 1'b0; drive(d, 4'h0, 16'h0, 0, 0, 0, 0, 0);
    expect_out(d, "t4_rst", M_REG, 1'b0, 4'h0, 3'd0, 1'b0);
    step(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); drive(d, 4'h0, pa[i], pc[i], pv[i], 1, 1, 0);
      expect_out(d, $sformatf("t4_push%0d", i), M_C | M_E, 1'b0, 4'h0, 3'(i), 1'b0);
    end
    step(); drive(d, 4'h0, 16'h0, 1, 0, 1, 1, 0);
    expect_out(d, "t4_full_pre", M_REG, 1'b0, 4'h1, 3'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(); drive(d, 4'h0, 16'h0, 0, 0, 0, 0, 1);
      expect_out(d, $sformatf("t4_pop%0d", i), M_REG, 1'b0,
                 (i == 0) ? 4'hA : st[4-i], 3'(4 - i), 1'b1);
    end
    step(); drive(d, 4'h0, nval(d), 0, 0, 1, 0, 1);
    expect_out(d, "t4_empty_pre", M_REG, 1'b0, st[0], 3'd0, 1'b1);
    step(); drive(d, 4'h0, 16'h0, 0, 0, 0, 0, 0);
    expect_out(d, "t4_underflow", M_REG, 1'b0, 4'h4, 3'd0, 1'b1);

    step(); rst_n = 1'b0;
    expect_out(d, "t5_rst", M_REG, 1'b0, 4'h0, 3'd0, 1'b0);
    step(); rst_n = 1'b1;
    step(); drive(d, 4'h0, 16'h0, 0, 0, 0, 1, 0);
    step(); drive(d, 4'h0, 16'h0, 0, 0, 0, 1, 0);
    expect_out(d, "t5_cnt1", M_C | M_E, 1'b0, 4'h0, 3'd1, 1'b0);
    step(); drive(d, 4'h0, 16'h0001, 1, 0, 1, 1, 1);
    expect_out(d, "t5_pre", M_C | M_E, 1'b0, 4'h0, 3'd2, 1'b0);
    step(); drive(d, 4'h0, 16'h0, 0, 0, 1, 1, 0);
    expect_out(d, "t5_collide", M_REG, 1'b0, 4'h2, 3'd2, 1'b1);
    step(); drive(d, 4'h0, 16'h0, 0, 0, 0, 0, 0);
    expect_out(d, "t6_pre", M_REG, 1'b0, 4'h8, 3'd3, 1'b1);
    step(); rst_n = 1'b0;
    expect_out(d, "t6_async", M_ALL, 1'b0, 4'h0, 3'd0, 1'b0);
    step(); rst_n = 1'b1;
  endtask

  initial begin
    drive(0, 4'h0, 16'h0, 0, 0, 0, 0, 0);
    drive(1, 4'h0, 16'h0, 0, 0, 0, 0, 0);
    step();
    seq_basic(0, 1'b1);
    seq_sweep(0);
    seq_stack(0, 1'b1);
    seq_basic(1, 1'b0);
    seq_sweep(1);
    seq_stack(1, 1'b0);
    step();
    step();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout actual=%0t required=<200000", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
